cache_control: RTL and testbench

- Sequencing FSM for the 4-way, 16-set, read-only L1 cache datapath (256-bit lines, 23-bit tag, 4-bit index, 5-bit offset).
- Accepts CPU-side line reads and checks hit/miss against the synchronous tag/valid arrays.
- On a miss, chooses a victim way (invalid-first, else tree-PLRU), runs the physical-memory refill, writes the line into the chosen way, then replays the lookup.
- Owns per-set PLRU state; drives the datapath's load strobes and per-way write enables.

---
 rtl/cache_control.sv | 146 ++++++++++++++
 tb/tb_cache_control.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// rtl/cache_control.sv - L1 read-only cache sequencing FSM with per-set tree-PLRU victim selection
// Optional build macro CACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module cache_control #(
  parameter int s_index  = 4,
  parameter int num_ways = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic [s_index-1:0]  mem_index,
  output logic                mem_resp,
  input  logic [num_ways-1:0] hit_way,
  input  logic [num_ways-1:0] valid_way,
  output logic                load_mem_rdata,
  output logic                load_cache,
  output logic [num_ways-1:0] way_we,
  output logic                pmem_read,
  input  logic                pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int num_sets = 2 ** s_index;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TAG_CHECK = 3'd1,
    ALLOCATE  = 3'd2,
    WRITE     = 3'd3,
    REREAD    = 3'd4
  } state_t;

  state_t     state;
  logic [1:0] victim;
  logic       replay;
  logic [2:0] plru [num_sets];

  logic       hit;
  logic [1:0] hit_idx;
  logic [2:0] plru_cur;
  logic [1:0] plru_victim;
  logic [1:0] invalid_victim;
  logic [1:0] miss_victim;
  logic       tc_active;

  // Tree-PLRU update: point the tree away from the way just accessed.
  function automatic logic [2:0] plru_next(input logic [2:0] cur, input logic [1:0] w);
    logic [2:0] n;
    n = cur;
    if (w[1] == 1'b0) begin
      n[0] = 1'b1;
      n[1] = (w == 2'd0);
    end else begin
      n[0] = 1'b0;
      n[2] = (w == 2'd2);
    end
    return n;
  endfunction

  // Hit detection, victim choice and PLRU lookup for the currently indexed set.
  always_comb begin
    hit      = |hit_way;
    plru_cur = plru[mem_index];

    // Lowest hit way wins so a corrupted multi-hit still yields a defined PLRU update.
    if (hit_way[0])      hit_idx = 2'd0;
    else if (hit_way[1]) hit_idx = 2'd1;
    else if (hit_way[2]) hit_idx = 2'd2;
    else                 hit_idx = 2'd3;

    if (plru_cur[0]) plru_victim = plru_cur[2] ? 2'd3 : 2'd2;
    else             plru_victim = plru_cur[1] ? 2'd1 : 2'd0;

    if (!valid_way[0])      invalid_victim = 2'd0;
    else if (!valid_way[1]) invalid_victim = 2'd1;
    else if (!valid_way[2]) invalid_victim = 2'd2;
    else                    invalid_victim = 2'd3;

    miss_victim = (&valid_way) ? plru_victim : invalid_victim;
  end

  // Strobes are decoded from the registered state; the hit response and the refill
  // write must land in the same cycle as hit_way / pmem_resp, and reset masks them all.
  always_comb begin
    tc_active      = !rst && (state == TAG_CHECK) && mem_read;
    mem_resp       = tc_active && hit;
    load_mem_rdata = tc_active && hit;
    pmem_read      = !rst && (state == ALLOCATE);
    load_cache     = pmem_read && pmem_resp;
    way_we         = load_cache ? (4'b0001 << victim) : '0;
  end

  // Main sequencer: state, victim latch, replay marker, PLRU and optional counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      victim <= 2'd0;
      replay <= 1'b0;
      for (int i = 0; i < num_sets; i++) begin
        plru[i] <= 3'b000;
      end
`ifdef CACHE_PERF_CNT_EN
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          replay <= 1'b0;
          if (mem_read) state <= TAG_CHECK;
        end
        TAG_CHECK: begin
          if (!mem_read) begin
            // Requester abandoned the access (possibly mid-miss): drop silently.
            state <= IDLE;
          end else if (hit) begin
            plru[mem_index] <= plru_next(plru_cur, hit_idx);
            state           <= IDLE;
`ifdef CACHE_PERF_CNT_EN
            if (!replay) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            victim <= miss_victim;
            state  <= ALLOCATE;
`ifdef CACHE_PERF_CNT_EN
            miss_count <= miss_count + 32'd1;
`endif
          end
        end
        ALLOCATE: begin
          if (pmem_resp) state <= REREAD;
        end
        REREAD: begin
          // Bubble while the arrays re-read the freshly written set.
          replay <= 1'b1;
          state  <= TAG_CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed self-checking bench for cache_control
module tb_cache_control;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic [3:0] mem_index;
  logic       mem_resp;
  logic [3:0] hit_way;
  logic [3:0] valid_way;
  logic       load_mem_rdata;
  logic       load_cache;
  logic [3:0] way_we;
  logic       pmem_read;
  logic       pmem_resp;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc_ctr = 0;

  cache_control #(.s_index(4), .num_ways(4)) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_index(mem_index),
    .mem_resp(mem_resp),
    .hit_way(hit_way),
    .valid_way(valid_way),
    .load_mem_rdata(load_mem_rdata),
    .load_cache(load_cache),
    .way_we(way_we),
    .pmem_read(pmem_read),
    .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  // One CPU access starting in the current cycle (caller sits just after a posedge).
  // Cycle 1 is the cycle mem_read is first high; the replay is made to hit the refilled way.
  task automatic run_access(input logic [3:0] idx, input logic [3:0] hw, input logic [3:0] vw,
                            input int lat, input bit keep,
                            output int resp_cyc, output int resp_time, output logic [3:0] we,
                            output int we_cycles, output bit pm_seen, output bit lmr,
                            output bit lc_ok);
    int pmcnt;
    pmcnt = 0; resp_cyc = 0; resp_time = 0; we = 4'b0; we_cycles = 0;
    pm_seen = 0; lmr = 0; lc_ok = 1;
    mem_read = 1'b1; mem_index = idx; hit_way = hw; valid_way = vw;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (pmem_read) begin
        pm_seen = 1;
        pmcnt++;
        pmem_resp = (pmcnt == lat);
      end else begin
        pmem_resp = 1'b0;
      end
      #1;
      if (way_we !== 4'b0) begin
        we = way_we;
        we_cycles++;
        if (load_cache !== 1'b1 || mem_resp !== 1'b0) lc_ok = 0;
        hit_way = way_we;
      end
      if (mem_resp === 1'b1) begin
        resp_cyc = cyc;
        resp_time = cyc_ctr;
        lmr = load_mem_rdata;
        break;
      end
    end
    if (resp_cyc == 0) begin
      n_cmp++; n_err++;
      $display("FAIL access_timeout idx=%0d: no mem_resp within 40 cycles", idx);
    end
    @(posedge clk); #1;
    if (!keep) mem_read = 1'b0;
    hit_way = 4'b0;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset;
    bit plru_zero;
    rst = 1'b1; mem_read = 1'b0; mem_index = 4'd0; hit_way = 4'b0; valid_way = 4'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_resp, load_mem_rdata, load_cache, way_we, pmem_read} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=0", {mem_resp, load_mem_rdata, load_cache, way_we, pmem_read});
    end
    n_cmp++;
    if (3'(dut.state) !== 3'd0) begin
      n_err++; $display("FAIL reset_state got=%0d want=0", dut.state);
    end
    plru_zero = 1;
    for (int i = 0; i < 16; i++) if (dut.plru[i] !== 3'b000) plru_zero = 0;
    n_cmp++;
    if (!plru_zero) begin
      n_err++; $display("FAIL reset_plru got=nonzero want=all 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss_invalid;
    int rc, rt, wc; logic [3:0] we; bit pm, lmr, lcok;
    run_access(4'd3, 4'b0000, 4'b0000, 5, 0, rc, rt, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (rc !== 9) begin n_err++; $display("FAIL miss_latency got=%0d want=9", rc); end
    n_cmp++;
    if (we !== 4'b0001 || wc !== 1) begin
      n_err++; $display("FAIL miss_way_we got=%b x%0d want=0001 x1", we, wc);
    end
    n_cmp++;
    if (!lcok) begin n_err++; $display("FAIL miss_load_cache got=bad want=load_cache with way_we, no mem_resp"); end
    n_cmp++;
    if (dut.plru[3] !== 3'b011) begin n_err++; $display("FAIL miss_plru3 got=%b want=011", dut.plru[3]); end
  endtask

  task automatic test_hit;
    int rc, rt, wc; logic [3:0] we; bit pm, lmr, lcok;
    run_access(4'd0, 4'b0010, 4'b1111, 5, 0, rc, rt, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (rc !== 2 || lmr !== 1'b1) begin
      n_err++; $display("FAIL hit_latency got=%0d lmr=%0d want=2 lmr=1", rc, lmr);
    end
    n_cmp++;
    if (pm !== 1'b0 || wc !== 0) begin
      n_err++; $display("FAIL hit_no_refill got pmem=%0d we_cycles=%0d want 0 0", pm, wc);
    end
    n_cmp++;
    if (dut.plru[0] !== 3'b001) begin n_err++; $display("FAIL hit_plru0 got=%b want=001", dut.plru[0]); end
  endtask

  task automatic test_fill_evict;
    int rc, rt, wc; logic [3:0] we; bit pm, lmr, lcok;
    logic [3:0] vws  [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
    logic [3:0] exps [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      run_access(4'd7, 4'b0000, vws[k], 2, 0, rc, rt, we, wc, pm, lmr, lcok);
      n_cmp++;
      if (we !== exps[k] || rc !== 6) begin
        n_err++; $display("FAIL fill%0d got we=%b rc=%0d want we=%b rc=6", k, we, rc, exps[k]);
      end
    end
    n_cmp++;
    if (dut.plru[7] !== 3'b000) begin n_err++; $display("FAIL fill_plru7 got=%b want=000", dut.plru[7]); end
    run_access(4'd7, 4'b0001, 4'b1111, 2, 0, rc, rt, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (dut.plru[7] !== 3'b011) begin n_err++; $display("FAIL hit7_plru got=%b want=011", dut.plru[7]); end
    run_access(4'd7, 4'b0000, 4'b1111, 2, 0, rc, rt, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (we !== 4'b0100) begin n_err++; $display("FAIL evict_plru_victim got=%b want=0100", we); end
    n_cmp++;
    if (dut.plru[7] !== 3'b110) begin n_err++; $display("FAIL evict_plru7 got=%b want=110", dut.plru[7]); end
  endtask

  task automatic test_multi_hit;
    int rc, rt, wc; logic [3:0] we; bit pm, lmr, lcok;
    run_access(4'd9, 4'b0110, 4'b1111, 2, 0, rc, rt, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (dut.plru[9] !== 3'b001) begin n_err++; $display("FAIL multi_hit_plru9 got=%b want=001", dut.plru[9]); end
  endtask

  task automatic test_reset_mid_refill;
    bit plru_zero;
    mem_read = 1'b1; mem_index = 4'd4; hit_way = 4'b0; valid_way = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1) begin n_err++; $display("FAIL rst_mid_alloc got pmem_read=%b want=1", pmem_read); end
    rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (way_we !== 4'b0 || load_cache !== 1'b0) begin
      n_err++; $display("FAIL rst_cycle_we got=%b lc=%b want=0000 0", way_we, load_cache);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (way_we !== 4'b0 || pmem_read !== 1'b0) begin
      n_err++; $display("FAIL rst_late_resp got we=%b pmem_read=%b want=0000 0", way_we, pmem_read);
    end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (3'(dut.state) !== 3'd0) begin n_err++; $display("FAIL rst_mid_state got=%0d want=0", dut.state); end
    plru_zero = 1;
    for (int i = 0; i < 16; i++) if (dut.plru[i] !== 3'b000) plru_zero = 0;
    n_cmp++;
    if (!plru_zero) begin n_err++; $display("FAIL rst_mid_plru got=nonzero want=all 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int rc1, rt1, rc2, rt2, wc; logic [3:0] we; bit pm, lmr, lcok;
    run_access(4'd2, 4'b0100, 4'b1111, 2, 1, rc1, rt1, we, wc, pm, lmr, lcok);
    run_access(4'd5, 4'b0010, 4'b1111, 2, 0, rc2, rt2, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (rt2 - rt1 !== 2) begin n_err++; $display("FAIL b2b_spacing got=%0d want=2", rt2 - rt1); end
    n_cmp++;
    if (dut.plru[2] !== 3'b100 || dut.plru[5] !== 3'b001) begin
      n_err++; $display("FAIL b2b_plru got p2=%b p5=%b want 100 001", dut.plru[2], dut.plru[5]);
    end
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf;
    int rc, rt, wc; logic [3:0] we; bit pm, lmr, lcok;
    test_reset();
    for (int k = 0; k < 3; k++) run_access(4'd1, 4'b0001, 4'b1111, 1, 0, rc, rt, we, wc, pm, lmr, lcok);
    for (int k = 0; k < 2; k++) run_access(4'd6, 4'b0000, 4'b0000, 1, 0, rc, rt, we, wc, pm, lmr, lcok);
    n_cmp++;
    if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
      n_err++; $display("FAIL perf_counts got hit=%0d miss=%0d want 3 2", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_index = 4'd0; hit_way = 4'b0; valid_way = 4'b0; pmem_resp = 1'b0;
    test_reset();
    test_miss_invalid();
    test_hit();
    test_fill_evict();
    test_multi_hit();
    test_reset_mid_refill();
    test_back_to_back();
`ifdef CACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
